// File: rtl/pipe_hazard_ctrl.sv
// Hazard and issue controller for the DEC/EXE/MEM/WB integer pipeline.
// Tracks rd of the EX and MEM occupants and decides issue/stall/bubble and forwarding.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid_i,
    input  logic [4:0]       dec_rs1_i,
    input  logic [4:0]       dec_rs2_i,
    input  logic             dec_rs1_used_i,
    input  logic             dec_rs2_used_i,
    input  logic [4:0]       dec_rd_i,
    input  logic             dec_is_load_i,
    input  logic             flush_i,
    input  logic             mem_busy_i,
    output logic             issue_o,
    output logic             stall_o,
    output logic             bubble_o,
    output logic [1:0]       fwd_rs1_sel_o,
    output logic [1:0]       fwd_rs2_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic       ex_vld, mem_vld;
    logic [4:0] ex_rd, mem_rd;
    logic       ex_ld, mem_ld;

    logic hit_ex1, hit_ex2, hit_mem1, hit_mem2, lu;

    always_comb begin
        hit_ex1  = dec_rs1_used_i & ex_vld  & (dec_rs1_i == ex_rd)  & (dec_rs1_i != 5'd0);
        hit_ex2  = dec_rs2_used_i & ex_vld  & (dec_rs2_i == ex_rd)  & (dec_rs2_i != 5'd0);
        hit_mem1 = dec_rs1_used_i & mem_vld & (dec_rs1_i == mem_rd) & (dec_rs1_i != 5'd0);
        hit_mem2 = dec_rs2_used_i & mem_vld & (dec_rs2_i == mem_rd) & (dec_rs2_i != 5'd0);
        lu       = (hit_ex1 | hit_ex2) & ex_ld;
    end

    // A flush outranks load-use, but a frozen memory stage outranks everything.
    always_comb begin
        stall_o  = mem_busy_i | (dec_valid_i & lu & ~flush_i);
        issue_o  = dec_valid_i & ~stall_o & ~flush_i;
        bubble_o = ~mem_busy_i & ~issue_o;
    end

    always_comb begin
        fwd_rs1_sel_o = 2'd0;
        fwd_rs2_sel_o = 2'd0;
        if (issue_o) begin
            if (hit_ex1 & ~ex_ld) fwd_rs1_sel_o = 2'd1;
            else if (hit_mem1)    fwd_rs1_sel_o = 2'd2;
            if (hit_ex2 & ~ex_ld) fwd_rs2_sel_o = 2'd1;
            else if (hit_mem2)    fwd_rs2_sel_o = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld  <= 1'b0;
            ex_rd   <= '0;
            ex_ld   <= 1'b0;
            mem_vld <= 1'b0;
            mem_rd  <= '0;
            mem_ld  <= 1'b0;
        end else if (!mem_busy_i) begin
            mem_vld <= ex_vld;
            mem_rd  <= ex_rd;
            mem_ld  <= ex_ld;
            ex_vld  <= issue_o & (dec_rd_i != 5'd0);
            ex_rd   <= dec_rd_i;
            ex_ld   <= dec_is_load_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (dec_valid_i && stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default-width instance plus a CNT_W=4 copy
// sharing the same stimulus for the saturation case.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_rs1_used, dec_rs2_used, dec_is_load;
    logic        flush, mem_busy;
    logic        issue, stall, bubble;
    logic [1:0]  sel1, sel2;
    logic [15:0] cnt16;
    logic        issue4, stall4, bubble4;
    logic [1:0]  sel1_4, sel2_4;
    logic [3:0]  cnt4;
    logic [6:0]  ctl;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .dec_valid_i(dec_valid),
        .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
        .dec_rs1_used_i(dec_rs1_used), .dec_rs2_used_i(dec_rs2_used),
        .dec_rd_i(dec_rd), .dec_is_load_i(dec_is_load),
        .flush_i(flush), .mem_busy_i(mem_busy),
        .issue_o(issue), .stall_o(stall), .bubble_o(bubble),
        .fwd_rs1_sel_o(sel1), .fwd_rs2_sel_o(sel2), .stall_cnt_o(cnt16)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .dec_valid_i(dec_valid),
        .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
        .dec_rs1_used_i(dec_rs1_used), .dec_rs2_used_i(dec_rs2_used),
        .dec_rd_i(dec_rd), .dec_is_load_i(dec_is_load),
        .flush_i(flush), .mem_busy_i(mem_busy),
        .issue_o(issue4), .stall_o(stall4), .bubble_o(bubble4),
        .fwd_rs1_sel_o(sel1_4), .fwd_rs2_sel_o(sel2_4), .stall_cnt_o(cnt4)
    );

    // {issue, stall, bubble, sel1, sel2}
    always_comb ctl = {issue, stall, bubble, sel1, sel2};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic ld);
        dec_valid = v; dec_rs1 = r1; dec_rs1_used = u1;
        dec_rs2 = r2; dec_rs2_used = u2; dec_rd = rd; dec_is_load = ld;
    endtask

    task automatic idle2();
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        flush = 1'b0; mem_busy = 1'b0;
        tick(); tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        flush = 1'b0; mem_busy = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (ctl !== 7'b001_00_00) $display("FAIL reset_ctl got %b want 0010000", ctl); else passed++;
        checks++; if (cnt16 !== 16'd0) $display("FAIL reset_cnt got %0d want 0", cnt16); else passed++;
        checks++; if (cnt4 !== 4'd0) $display("FAIL reset_cnt4 got %0d want 0", cnt4); else passed++;
        tick();
    endtask

    task automatic test_alu_chain();
        dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0);   // addi x5,x1
        #1;
        checks++; if (ctl !== 7'b100_00_00) $display("FAIL alu_first got %b want 1000000", ctl); else passed++;
        tick();
        dec(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0);   // add x6,x5,x5
        #1;
        checks++; if (ctl !== 7'b100_01_01) $display("FAIL alu_fwd got %b want 1000101", ctl); else passed++;
        tick();
        idle2();
    endtask

    task automatic test_load_use();
        do_reset();
        dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);   // lw x7
        #1;
        checks++; if (ctl !== 7'b100_00_00) $display("FAIL lu_load got %b want 1000000", ctl); else passed++;
        tick();
        dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b0);   // add x8,x7,x0
        #1;
        checks++; if (ctl !== 7'b011_00_00) $display("FAIL lu_stall got %b want 0110000", ctl); else passed++;
        tick();
        #1;
        checks++; if (ctl !== 7'b100_10_00) $display("FAIL lu_issue got %b want 1001000", ctl); else passed++;
        checks++; if (cnt16 !== 16'd1) $display("FAIL lu_cnt got %0d want 1", cnt16); else passed++;
        tick();
        idle2();
    endtask

    task automatic test_distance();
        dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0);   // addi x3
        tick();
        dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0);  // unrelated
        tick();
        dec(1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0);   // sub x4,x3,x0
        #1;
        checks++; if (ctl !== 7'b100_10_00) $display("FAIL dist2 got %b want 1001000", ctl); else passed++;
        tick();
        idle2();
        dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0);
        tick();
        dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0);
        tick();
        dec(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0);
        #1;
        checks++; if (ctl !== 7'b100_01_01) $display("FAIL ex_priority got %b want 1000101", ctl); else passed++;
        tick();
        idle2();
    endtask

    task automatic test_x0_unused();
        dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);   // addi x0
        tick();
        dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b0);  // reader of x0
        #1;
        checks++; if (ctl !== 7'b100_00_00) $display("FAIL x0_read got %b want 1000000", ctl); else passed++;
        tick();
        dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1);   // lw x9
        tick();
        dec(1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd9, 1'b0);   // lui x9
        #1;
        checks++; if (ctl !== 7'b100_00_00) $display("FAIL unused_src got %b want 1000000", ctl); else passed++;
        tick();
        idle2();
    endtask

    task automatic test_mem_busy();
        do_reset();
        dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b0);  // addi x12
        tick();
        dec(1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 5'd13, 1'b0);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== 7'b010_00_00) $display("FAIL busy_%0d got %b want 0100000", i, ctl); else passed++;
            tick();
        end
        mem_busy = 1'b0;
        #1;
        checks++; if (ctl !== 7'b100_01_01) $display("FAIL busy_frozen got %b want 1000101", ctl); else passed++;
        checks++; if (cnt16 !== 16'd3) $display("FAIL busy_cnt got %0d want 3", cnt16); else passed++;
        tick();
        dec(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b0);
        mem_busy = 1'b1; flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (ctl !== 7'b010_00_00) $display("FAIL busy_flush_%0d got %b want 0100000", i, ctl); else passed++;
            tick();
        end
        mem_busy = 1'b0;
        #1;
        checks++; if (ctl !== 7'b001_00_00) $display("FAIL flush_drop got %b want 0010000", ctl); else passed++;
        checks++; if (cnt16 !== 16'd5) $display("FAIL busy_flush_cnt got %0d want 5", cnt16); else passed++;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (ctl !== 7'b100_10_00) $display("FAIL flush_advance got %b want 1001000", ctl); else passed++;
        tick();
        idle2();
    endtask

    task automatic test_flush_lu();
        do_reset();
        dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
        tick();
        dec(1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0);
        flush = 1'b1;
        #1;
        checks++; if (ctl !== 7'b001_00_00) $display("FAIL flush_lu got %b want 0010000", ctl); else passed++;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (ctl !== 7'b100_00_10) $display("FAIL flush_lu_next got %b want 1000010", ctl); else passed++;
        checks++; if (cnt16 !== 16'd0) $display("FAIL flush_lu_cnt got %0d want 0", cnt16); else passed++;
        tick();
        idle2();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
        tick();
        dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0);
        mem_busy = 1'b1;
        tick(); tick();
        mem_busy = 1'b0;
        #1;
        checks++; if (ctl !== 7'b011_00_00) $display("FAIL pre_rst_stall got %b want 0110000", ctl); else passed++;
        checks++; if (cnt16 !== 16'd2) $display("FAIL pre_rst_cnt got %0d want 2", cnt16); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (ctl !== 7'b100_00_00) $display("FAIL async_slot_clear got %b want 1000000", ctl); else passed++;
        checks++; if (cnt16 !== 16'd0) $display("FAIL async_cnt_clear got %0d want 0", cnt16); else passed++;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (ctl !== 7'b100_00_00) $display("FAIL post_rst_issue got %b want 1000000", ctl); else passed++;
        tick();
        idle2();
    endtask

    task automatic test_saturation();
        do_reset();
        dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
        tick();
        dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0);
        mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) begin
                checks++; if (cnt4 !== 4'd14) $display("FAIL sat_pre got %0d want 14", cnt4); else passed++;
            end
        end
        checks++; if (cnt4 !== 4'd15) $display("FAIL sat_hold got %0d want 15", cnt4); else passed++;
        checks++; if (cnt16 !== 16'd20) $display("FAIL sat_wide got %0d want 20", cnt16); else passed++;
        mem_busy = 1'b0;
        #1;
        checks++; if (ctl !== 7'b011_00_00) $display("FAIL sat_lu got %b want 0110000", ctl); else passed++;
        tick();
        #1;
        checks++; if (ctl !== 7'b100_10_00) $display("FAIL sat_issue got %b want 1001000", ctl); else passed++;
        checks++; if (cnt4 !== 4'd15) $display("FAIL sat_final got %0d want 15", cnt4); else passed++;
        tick();
        idle2();
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_distance();
        test_x0_unused();
        test_mem_busy();
        test_flush_lu();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
